// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles every bus signal of the picoMIPS fetch stage:
//   - program-memory side : imem_req, imem_addr, imem_rdata, imem_valid
//   - decoder side        : instr, instr_valid, instr_ready
//   - PC control          : pc_incr, pc_relbranch, branch_offset, pc
// Modports:
//   master - the fetch unit itself (drives request, instruction and PC)
//   slave  - its environment (program memory plus decoder)
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
   parameter int PSIZE = 6,
   parameter int ISIZE = 20,
   parameter int OSIZE = 6
);
   logic             imem_req;
   logic [PSIZE-1:0] imem_addr;
   logic [ISIZE-1:0] imem_rdata;
   logic             imem_valid;
   logic [ISIZE-1:0] instr;
   logic             instr_valid;
   logic             instr_ready;
   logic             pc_incr;
   logic             pc_relbranch;
   logic [OSIZE-1:0] branch_offset;
   logic [PSIZE-1:0] pc;

   modport master (
      output imem_req, imem_addr, instr, instr_valid, pc,
      input  imem_rdata, imem_valid, instr_ready, pc_incr, pc_relbranch, branch_offset
   );

   modport slave (
      input  imem_req, imem_addr, instr, instr_valid, pc,
      output imem_rdata, imem_valid, instr_ready, pc_incr, pc_relbranch, branch_offset
   );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage of picoMIPS. Holds the PC, requests one word from
// program memory, parks it in the instruction register until the decoder
// takes it, then moves the PC (increment, relative branch, or stay put).
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-low reset
//   bus    - fetch_unit_if.master: program-memory request/response,
//            instruction handshake to the decoder, PC controls and PC value
// Throughput is one instruction per two cycles (FETCH then HOLD); there is
// no prefetch and only the single instruction register as buffering.
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int PSIZE = 6,
   parameter int ISIZE = 20,
   parameter int OSIZE = 6
) (
   input  logic           clk,
   input  logic           reset,
   fetch_unit_if.master   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [PSIZE-1:0] pc_q, pc_d;
   logic [PSIZE-1:0] offset_ext;
   logic [ISIZE-1:0] instr_q, instr_d;
   logic             valid_q, valid_d;
   logic             req_q, req_d;

   // Sign-extend the branch offset to PC width; the add below then wraps
   // modulo 2**PSIZE, which is exactly the required negative-offset behaviour.
   assign offset_ext = PSIZE'($signed(bus.branch_offset));

   // Next-state and next-register values.
   // NOTE: every signal gets its hold value first so no path leaves it
   // unassigned; that is what keeps this block from inferring latches.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;

      case (state_q)
         IDLE: begin
            state_d = FETCH;
         end

         FETCH: begin
            // Memory response is only looked at here.
            if (bus.imem_valid) begin
               instr_d = bus.imem_rdata;
               valid_d = 1'b1;
               state_d = HOLD;
            end
         end

         HOLD: begin
            // instr_valid is always 1 in HOLD, so ready alone marks a transfer.
            if (bus.instr_ready) begin
               valid_d = 1'b0;
               state_d = FETCH;
               if (bus.pc_relbranch) begin
                  pc_d = pc_q + offset_ext;
               end else if (bus.pc_incr) begin
                  pc_d = pc_q + PSIZE'(1);
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Request is registered: it is high exactly while the FSM sits in FETCH.
      req_d = (state_d == FETCH);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         req_q   <= req_d;
      end
   end

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = pc_q;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed, table-driven bench for fetch_unit. Each table record describes one
// instruction's life: the address it must be fetched from, the memory latency,
// the word returned, how long the decoder stalls, the PC controls presented on
// accept, and the hand-computed next PC. Reset corner cases are hand-written.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam int PSIZE = 6;
   localparam int ISIZE = 20;
   localparam int OSIZE = 6;
   localparam int NVEC  = 14;

   logic clk = 1'b0;
   logic reset;

   fetch_unit_if #(.PSIZE(PSIZE), .ISIZE(ISIZE), .OSIZE(OSIZE)) bus ();

   fetch_unit #(.PSIZE(PSIZE), .ISIZE(ISIZE), .OSIZE(OSIZE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             incr;
      logic             rel;
      logic [OSIZE-1:0] off;
      logic [ISIZE-1:0] data;
      int               lat;
      int               hold;
      logic [PSIZE-1:0] addr;
      logic [PSIZE-1:0] next;
   } vec_t;

   vec_t vecs [NVEC];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (bus.imem_req !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      check(name, 32'(bus.imem_req), 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      wait_req($sformatf("v%0d_req", idx));
      check($sformatf("v%0d_addr", idx), 32'(bus.imem_addr), 32'(v.addr));
      check($sformatf("v%0d_pc", idx), 32'(bus.pc), 32'(v.addr));

      // Late memory: garbage on rdata, ready waved while nothing is valid.
      for (int i = 0; i < v.lat; i++) begin
         bus.imem_valid  = 1'b0;
         bus.imem_rdata  = ~v.data;
         bus.instr_ready = 1'b1;
         bus.pc_incr     = 1'b1;
         tick();
         check($sformatf("v%0d_wait_valid", idx), 32'(bus.instr_valid), 32'd0);
         check($sformatf("v%0d_wait_req", idx), 32'(bus.imem_req), 32'd1);
      end

      bus.instr_ready = 1'b0;
      bus.imem_valid  = 1'b1;
      bus.imem_rdata  = v.data;
      tick();
      // Keep memory talking with wrong data; it must be ignored outside FETCH.
      bus.imem_rdata  = ~v.data;
      check($sformatf("v%0d_instr", idx), 32'(bus.instr), 32'(v.data));
      check($sformatf("v%0d_ivalid", idx), 32'(bus.instr_valid), 32'd1);
      check($sformatf("v%0d_req_low", idx), 32'(bus.imem_req), 32'd0);

      for (int i = 0; i < v.hold; i++) begin
         bus.pc_incr       = 1'b1;
         bus.pc_relbranch  = 1'b1;
         bus.branch_offset = 6'b010101;
         tick();
         check($sformatf("v%0d_hold_instr", idx), 32'(bus.instr), 32'(v.data));
         check($sformatf("v%0d_hold_valid", idx), 32'(bus.instr_valid), 32'd1);
         check($sformatf("v%0d_hold_pc", idx), 32'(bus.pc), 32'(v.addr));
         check($sformatf("v%0d_hold_req", idx), 32'(bus.imem_req), 32'd0);
      end

      bus.imem_valid    = 1'b0;
      bus.instr_ready   = 1'b1;
      bus.pc_incr       = v.incr;
      bus.pc_relbranch  = v.rel;
      bus.branch_offset = v.off;
      tick();
      bus.instr_ready   = 1'b0;
      bus.pc_incr       = 1'b0;
      bus.pc_relbranch  = 1'b0;
      check($sformatf("v%0d_after_valid", idx), 32'(bus.instr_valid), 32'd0);
      check($sformatf("v%0d_after_req", idx), 32'(bus.imem_req), 32'd1);
      check($sformatf("v%0d_next_addr", idx), 32'(bus.imem_addr), 32'(v.next));
   endtask

   // Hard bound on total run time.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      //          incr rel  off         data       lat hold addr   next
      vecs[0]  = '{1'b1, 1'b0, 6'b000000, 20'h12345, 0, 0, 6'd0,  6'd1};
      vecs[1]  = '{1'b1, 1'b0, 6'b000000, 20'h12345, 0, 5, 6'd1,  6'd2};
      vecs[2]  = '{1'b0, 1'b1, 6'b111101, 20'hABCDE, 1, 0, 6'd2,  6'd63}; // 2-3 -> 63
      vecs[3]  = '{1'b1, 1'b0, 6'b000000, 20'h00001, 0, 1, 6'd63, 6'd0};  // wrap
      vecs[4]  = '{1'b0, 1'b1, 6'b001010, 20'hFFFFF, 2, 0, 6'd0,  6'd10};
      vecs[5]  = '{1'b0, 1'b1, 6'b111100, 20'h5A5A5, 0, 0, 6'd10, 6'd6};  // 10-4
      vecs[6]  = '{1'b0, 1'b1, 6'b000100, 20'hA5A5A, 0, 2, 6'd6,  6'd10};
      vecs[7]  = '{1'b1, 1'b1, 6'b111100, 20'h0F0F0, 1, 0, 6'd10, 6'd6};  // branch wins
      vecs[8]  = '{1'b0, 1'b0, 6'b011011, 20'h33333, 0, 0, 6'd6,  6'd6};  // refetch
      vecs[9]  = '{1'b0, 1'b1, 6'b011111, 20'h44444, 0, 0, 6'd6,  6'd37};
      vecs[10] = '{1'b0, 1'b1, 6'b010111, 20'h55555, 0, 0, 6'd37, 6'd60};
      vecs[11] = '{1'b0, 1'b1, 6'b000111, 20'h66666, 0, 0, 6'd60, 6'd3};  // 60+7 -> 3
      vecs[12] = '{1'b0, 1'b1, 6'b100000, 20'h77777, 0, 0, 6'd3,  6'd35}; // 3-32
      vecs[13] = '{1'b1, 1'b0, 6'b000000, 20'h9C3E1, 3, 1, 6'd35, 6'd36};

      // Reset asserted with memory already claiming valid data.
      reset             = 1'b0;
      bus.imem_valid    = 1'b1;
      bus.imem_rdata    = 20'h12345;
      bus.instr_ready   = 1'b0;
      bus.pc_incr       = 1'b0;
      bus.pc_relbranch  = 1'b0;
      bus.branch_offset = '0;
      #22;
      check("rst_pc", 32'(bus.pc), 32'd0);
      check("rst_instr", 32'(bus.instr), 32'd0);
      check("rst_ivalid", 32'(bus.instr_valid), 32'd0);
      check("rst_req", 32'(bus.imem_req), 32'd0);
      bus.imem_valid = 1'b0;
      reset = 1'b1;

      for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

      // Reset mid-FETCH (pc=36) with imem_valid arriving during reset.
      #2;
      reset          = 1'b0;
      bus.imem_valid = 1'b1;
      bus.imem_rdata = 20'hDEAD1;
      #1;
      check("rstf_pc", 32'(bus.pc), 32'd0);
      check("rstf_ivalid", 32'(bus.instr_valid), 32'd0);
      check("rstf_req", 32'(bus.imem_req), 32'd0);
      tick();
      check("rstf_hold_ivalid", 32'(bus.instr_valid), 32'd0);
      check("rstf_hold_instr", 32'(bus.instr), 32'd0);
      #2;
      reset = 1'b1;
      // First edge after release: IDLE -> FETCH; valid still ignored there.
      tick();
      check("rstf_idle_ivalid", 32'(bus.instr_valid), 32'd0);
      check("rstf_refetch_req", 32'(bus.imem_req), 32'd1);
      check("rstf_refetch_addr", 32'(bus.imem_addr), 32'd0);
      bus.imem_valid = 1'b0;

      // Advance to pc=1, then reset mid-HOLD.
      run_vec('{1'b1, 1'b0, 6'b0, 20'h2468A, 0, 0, 6'd0, 6'd1}, 100);
      bus.imem_valid = 1'b1;
      bus.imem_rdata = 20'hBEEF0;
      tick();
      check("rsth_pre_ivalid", 32'(bus.instr_valid), 32'd1);
      check("rsth_pre_pc", 32'(bus.pc), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("rsth_pc", 32'(bus.pc), 32'd0);
      check("rsth_ivalid", 32'(bus.instr_valid), 32'd0);
      check("rsth_instr", 32'(bus.instr), 32'd0);
      check("rsth_req", 32'(bus.imem_req), 32'd0);
      #4;
      bus.imem_valid = 1'b0;
      reset = 1'b1;
      run_vec('{1'b1, 1'b0, 6'b0, 20'h13579, 1, 0, 6'd0, 6'd1}, 101);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
